uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Frame controller for the UART transmit path, sitting directly downstream of the
//  8-bit serializer. Accepts a parallel byte handshake, commands the serializer
//  shift (SER_EN), computes parity and drives the line with start, data, parity and stop bits.
//  Its output TX_OUT is the UART TX pin. BUSY feeds back to both the data source and the serializer load gate.
// PARAMETERS
//  WIDTH      8  data bits per frame; only 8 is supported, to match the 3-bit serializer counter.
//  STOP_BITS  1  stop bits per frame; legal values are 1 or 2.
// PORTS
//  CLK         in   1      system clock, rising edge
//  RST         in   1      asynchronous reset, active-high
//  P_DATA      in   WIDTH  parallel byte; used only for the parity calculation
//  DATA_VALID  in   1      byte valid; accepted when DATA_VALID && !BUSY
//  PAR_EN      in   1      1 = insert parity bit
//  PAR_TYP     in   1      0 = even parity, 1 = odd parity
//  SER_DONE    in   1      from serializer: high during the 8th shift cycle
//  SER_DATA    in   1      from serializer: current LSB
//  SER_EN      out  1      to serializer: shift enable
//  TX_OUT      out  1      serial line, registered, idle high
//  BUSY        out  1      frame in progress; source must not change P_DATA
//  FRAME_DONE  out  1      one-cycle pulse on the last stop-bit cycle of the line
// BEHAVIOUR
//  Reset: async, high. Values while reset is high and after release:
//   - state = IDLE
//   - TX_OUT = 1, BUSY = 0, SER_EN = 0, FRAME_DONE = 0
//   - parity and config registers = 0
//   Reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit.
//  Accept: in IDLE, on a rising edge with DATA_VALID && !BUSY:
//   - latch PAR_EN and PAR_TYP
//   - latch par = ^P_DATA ^ PAR_TYP
//   - go to START
//   - config changes after accept have no effect on the current frame
//  FSM, one cycle per state unless noted:
//   IDLE   sel=1
//   START  sel=0; next DATA
//   DATA   sel=SER_DATA, SER_EN=1; lasts 8 cycles
//          on SER_DONE: next PARITY if the latched PAR_EN is set, else STOP
//   PARITY sel=par; next STOP
//   STOP   sel=1; STOP_BITS cycles (internal stop counter); next IDLE
//  SER_EN: combinational, = (state==DATA). Never high in any other state.
//  Bit-count guard: an internal 3-bit counter also tracks DATA cycles.
//   - if SER_DONE is absent when the counter reaches 7, leave DATA anyway
//   - SER_DONE before count 7 is ignored
//  TX_OUT: register loaded with sel every cycle.
//   - the line lags the state by exactly 1 cycle
//   - the start bit appears on the line on the 2nd edge after accept
//  BUSY: = (state != IDLE). Combinational from the state register, glitch-free.
//   - no accept is possible during any frame state, including STOP
//   - minimum spacing between accepts = frame length + 1 cycle
//  FRAME_DONE: registered. High in the cycle TX_OUT carries the last stop bit.
//  Frame on the line: 0, D0..D7 LSB first, [P], 1 x STOP_BITS.
//   - total 10 or 11 cycles with STOP_BITS=1, plus 1 cycle per extra stop bit
//  DATA_VALID while BUSY: ignored, no side effects.
//  DATA_VALID held high through IDLE: the next frame is accepted on the first IDLE cycle.
// TESTING
//  1. Reset mid-DATA (after 3 data bits): TX_OUT=1 and BUSY=0 within the reset cycle;
//     SER_EN=0; after release, a fresh 0x0F frame is clean.
//  2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0: line 0,1,0,1,0,0,1,0,1,0,1 (11 cycles).
//     FRAME_DONE on the final 1. SER_EN high exactly 8 cycles.
//  3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=1: parity bit = 1; all other bits as in test 2.
//  4. P_DATA=0xFF, PAR_EN=0: line 0,1x8,1 (10 cycles). BUSY high 10 cycles.
//     DATA_VALID pulsed mid-frame with 0x00 is ignored.
//  5. DATA_VALID held high, bytes 0x01 then 0x80, STOP_BITS=2:
//     two back-to-back frames separated by exactly 1 idle cycle;
//     PAR_EN toggled mid-frame does not alter the current frame.
//  6. SER_DONE stuck low: the framer still exits DATA after 8 cycles
//     and completes the frame with the correct stop bit(s).

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART TX frame controller driving start, data, parity and stop bits onto the line
module uart_tx_framer #(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] p_data_i,
  input  logic             data_valid_i,
  input  logic             par_en_i,
  input  logic             par_typ_i,
  input  logic             ser_done_i,
  input  logic             ser_data_i,
  output logic             ser_en_o,
  output logic             tx_out_o,
  output logic             busy_o,
  output logic             frame_done_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stop_q, stop_d;
  logic       par_q, par_d;
  logic       par_en_q, par_en_d;
  logic       tx_q, fd_q, fd_d;
  logic       sel, last_bit, data_end, stop_last;
  assign last_bit  = cnt_q == 3'd7;
  // SER_DONE is honoured only on the 8th cycle; the counter guarantees exit even without it
  assign data_end  = (ser_done_i && last_bit) || last_bit;
  assign stop_last = (STOP_BITS == 1) || stop_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    sel      = 1'b1;
    fd_d     = 1'b0;
    case (state_q)
      IDLE: if (data_valid_i) begin
        state_d  = START;
        par_en_d = par_en_i;
        par_d    = ^p_data_i ^ par_typ_i;
        cnt_d    = 3'd0;
        stop_d   = 1'b0;
      end
      START: begin
        sel     = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        sel     = ser_data_i;
        cnt_d   = cnt_q + 3'd1;
        state_d = data_end ? (par_en_q ? PARITY : STOP) : DATA;
      end
      PARITY: begin
        sel     = par_q;
        state_d = STOP;
      end
      STOP: begin
        stop_d  = ~stop_q;
        state_d = stop_last ? IDLE : STOP;
        fd_d    = stop_last;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= sel;
      fd_q     <= fd_d;
    end
  end
  assign ser_en_o     = state_q == DATA;
  assign busy_o       = state_q != IDLE;
  assign tx_out_o     = tx_q;
  assign frame_done_o = fd_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed checks of two framers (1 and 2 stop bits) driven by a serializer model
module tb_uart_tx_framer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       dv = 1'b0, par_en = 1'b0, par_typ = 1'b0, stuck = 1'b0;
  int         which = 0;
  int         n_chk = 0, n_fail = 0;
  logic [1:0] dvv, sd, sdat, sen, tx, busy, fd;
  logic [7:0] sh [2];
  logic [2:0] sc [2];
  always #5 clk = ~clk;
  assign dvv[0]  = dv && which == 0;
  assign dvv[1]  = dv && which == 1;
  assign sdat[0] = sh[0][0];
  assign sdat[1] = sh[1][0];
  assign sd[0]   = !stuck && sen[0] && sc[0] == 3'd7;
  assign sd[1]   = !stuck && sen[1] && sc[1] == 3'd7;
  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        sh[j] <= 8'h00;
        sc[j] <= 3'd0;
      end else if (dvv[j] && !busy[j]) begin
        sh[j] <= p_data;
        sc[j] <= 3'd0;
      end else if (sen[j]) begin
        sh[j] <= {1'b0, sh[j][7:1]};
        sc[j] <= sc[j] + 3'd1;
      end
    end
  end
  uart_tx_framer #(.WIDTH(8), .STOP_BITS(1)) u1 (
    .clk_i(clk), .rst_i(rst), .p_data_i(p_data), .data_valid_i(dvv[0]),
    .par_en_i(par_en), .par_typ_i(par_typ), .ser_done_i(sd[0]), .ser_data_i(sdat[0]),
    .ser_en_o(sen[0]), .tx_out_o(tx[0]), .busy_o(busy[0]), .frame_done_o(fd[0])
  );
  uart_tx_framer #(.WIDTH(8), .STOP_BITS(2)) u2 (
    .clk_i(clk), .rst_i(rst), .p_data_i(p_data), .data_valid_i(dvv[1]),
    .par_en_i(par_en), .par_typ_i(par_typ), .ser_done_i(sd[1]), .ser_data_i(sdat[1]),
    .ser_en_o(sen[1]), .tx_out_o(tx[1]), .busy_o(busy[1]), .frame_done_o(fd[1])
  );
  // Bit k of each vector is sampled on the falling edge after the k-th rising edge past accept
  task automatic capture(input int j, input int n, input int mode,
                         output logic [31:0] l, output logic [31:0] b,
                         output logic [31:0] s, output logic [31:0] f);
    l = '0; b = '0; s = '0; f = '0;
    @(posedge clk);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      l[k] = tx[j]; b[k] = busy[j]; s[k] = sen[j]; f[k] = fd[j];
      if (mode != 5 && k == 0) dv = 1'b0;
      if (mode == 4 && k == 4) begin dv = 1'b1; p_data = 8'h00; end
      if (mode == 4 && k == 5) dv = 1'b0;
      if (mode == 5 && k == 4) par_en = 1'b0;
      if (mode == 5 && k == 12) p_data = 8'h80;
      if (mode == 5 && k == 13) dv = 1'b0;
    end
  endtask
  task automatic start(input int j, input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    which = j; p_data = d; par_en = pe; par_typ = pt; dv = 1'b1;
  endtask
  task automatic test_reset;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_chk += 4;
      if (tx[j] !== 1'b1) begin n_fail++; $display("FAIL rst_tx%0d got %b exp 1", j, tx[j]); end
      if (busy[j] !== 1'b0) begin n_fail++; $display("FAIL rst_busy%0d got %b exp 0", j, busy[j]); end
      if (sen[j] !== 1'b0) begin n_fail++; $display("FAIL rst_sen%0d got %b exp 0", j, sen[j]); end
      if (fd[j] !== 1'b0) begin n_fail++; $display("FAIL rst_fd%0d got %b exp 0", j, fd[j]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk += 2;
    if (tx !== 2'b11) begin n_fail++; $display("FAIL idle_tx got %b exp 11", tx); end
    if (busy !== 2'b00) begin n_fail++; $display("FAIL idle_busy got %b exp 00", busy); end
  endtask
  task automatic test_reset_mid_frame;
    logic [31:0] l, b, s, f;
    start(0, 8'h55, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    dv = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy[0]); end
    rst = 1'b1;
    #1;
    n_chk += 4;
    if (tx[0] !== 1'b1) begin n_fail++; $display("FAIL abort_tx got %b exp 1", tx[0]); end
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy[0]); end
    if (sen[0] !== 1'b0) begin n_fail++; $display("FAIL abort_sen got %b exp 0", sen[0]); end
    if (fd[0] !== 1'b0) begin n_fail++; $display("FAIL abort_fd got %b exp 0", fd[0]); end
    @(posedge clk);
    #1;
    n_chk++;
    if (tx[0] !== 1'b1) begin n_fail++; $display("FAIL hold_tx got %b exp 1", tx[0]); end
    @(negedge clk);
    rst = 1'b0;
    start(0, 8'h0F, 1'b0, 1'b0);
    capture(0, 10, 0, l, b, s, f);
    n_chk += 4;
    if (l !== 32'h43D) begin n_fail++; $display("FAIL post_rst_line got %h exp 43d", l); end
    if (f !== 32'h400) begin n_fail++; $display("FAIL post_rst_fd got %h exp 400", f); end
    if (b !== 32'h3FF) begin n_fail++; $display("FAIL post_rst_busy got %h exp 3ff", b); end
    if (s !== 32'h1FE) begin n_fail++; $display("FAIL post_rst_sen got %h exp 1fe", s); end
  endtask
  task automatic test_parity;
    logic [31:0] l, b, s, f;
    start(0, 8'hA5, 1'b1, 1'b0);
    capture(0, 11, 0, l, b, s, f);
    n_chk += 4;
    if (l !== 32'hA95) begin n_fail++; $display("FAIL even_line got %h exp a95", l); end
    if (f !== 32'h800) begin n_fail++; $display("FAIL even_fd got %h exp 800", f); end
    if (b !== 32'h7FF) begin n_fail++; $display("FAIL even_busy got %h exp 7ff", b); end
    if (s !== 32'h1FE) begin n_fail++; $display("FAIL even_sen got %h exp 1fe", s); end
    start(0, 8'hA5, 1'b1, 1'b1);
    capture(0, 11, 0, l, b, s, f);
    n_chk += 2;
    if (l !== 32'hE95) begin n_fail++; $display("FAIL odd_line got %h exp e95", l); end
    if (f !== 32'h800) begin n_fail++; $display("FAIL odd_fd got %h exp 800", f); end
  endtask
  task automatic test_no_parity;
    logic [31:0] l, b, s, f;
    start(0, 8'hFF, 1'b0, 1'b0);
    capture(0, 10, 4, l, b, s, f);
    n_chk += 4;
    if (l !== 32'h7FD) begin n_fail++; $display("FAIL nopar_line got %h exp 7fd", l); end
    if (f !== 32'h400) begin n_fail++; $display("FAIL nopar_fd got %h exp 400", f); end
    if (b !== 32'h3FF) begin n_fail++; $display("FAIL nopar_busy got %h exp 3ff", b); end
    if (s !== 32'h1FE) begin n_fail++; $display("FAIL nopar_sen got %h exp 1fe", s); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] l, b, s, f;
    start(1, 8'h01, 1'b1, 1'b0);
    capture(1, 24, 5, l, b, s, f);
    n_chk += 4;
    if (l !== 32'h1C03C05) begin n_fail++; $display("FAIL b2b_line got %h exp 1c03c05", l); end
    if (f !== 32'h1001000) begin n_fail++; $display("FAIL b2b_fd got %h exp 1001000", f); end
    if (b !== 32'hFFEFFF) begin n_fail++; $display("FAIL b2b_busy got %h exp ffefff", b); end
    if (s !== 32'h3FC1FE) begin n_fail++; $display("FAIL b2b_sen got %h exp 3fc1fe", s); end
  endtask
  task automatic test_ser_done_stuck;
    logic [31:0] l, b, s, f;
    stuck = 1'b1;
    start(0, 8'h3C, 1'b1, 1'b0);
    capture(0, 11, 0, l, b, s, f);
    n_chk += 3;
    if (l !== 32'h8F1) begin n_fail++; $display("FAIL stuck1_line got %h exp 8f1", l); end
    if (f !== 32'h800) begin n_fail++; $display("FAIL stuck1_fd got %h exp 800", f); end
    if (s !== 32'h1FE) begin n_fail++; $display("FAIL stuck1_sen got %h exp 1fe", s); end
    start(1, 8'h3C, 1'b0, 1'b0);
    capture(1, 11, 0, l, b, s, f);
    n_chk += 3;
    if (l !== 32'hCF1) begin n_fail++; $display("FAIL stuck2_line got %h exp cf1", l); end
    if (f !== 32'h800) begin n_fail++; $display("FAIL stuck2_fd got %h exp 800", f); end
    if (b !== 32'h7FF) begin n_fail++; $display("FAIL stuck2_busy got %h exp 7ff", b); end
    stuck = 1'b0;
  endtask
  initial begin
    test_reset;
    test_reset_mid_frame;
    test_parity;
    test_no_parity;
    test_back_to_back;
    test_ser_done_stuck;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
